// File: rtl/button_event.sv
// button_event: turns a debounced button level into single-cycle press,
// long-press and auto-repeat pulses. Hold timing counts tick_fast strobes.
// Optional: define BTN_RELEASE_PULSE_EN to add a one-clk release_pulse output.
module button_event #(
  parameter int LONG_TICKS   = 200,
  parameter int REPEAT_TICKS = 40
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_fast,
  input  logic btn_deb,
  output logic press,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
`ifdef BTN_RELEASE_PULSE_EN
  , output logic release_pulse
`endif
);

  localparam int MAX_TICKS = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int CW        = $clog2(MAX_TICKS + 1);
  localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_TICKS - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    REPEAT  = 2'd2
  } state_t;

  state_t          state_reg;
  logic [CW-1:0]   count_reg;
  // A button held through reset must be released once before it counts.
  logic            armed_reg;

  // Hold FSM with registered event pulses; release always beats a terminal tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      armed_reg    <= 1'b0;
      press        <= 1'b0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;
      held         <= 1'b0;
`ifdef BTN_RELEASE_PULSE_EN
      release_pulse <= 1'b0;
`endif
    end else begin
      press        <= 1'b0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;
`ifdef BTN_RELEASE_PULSE_EN
      release_pulse <= 1'b0;
`endif
      if (!btn_deb) begin
        armed_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (armed_reg && btn_deb) begin
            state_reg <= PRESSED;
            count_reg <= '0;
            press     <= 1'b1;
            held      <= 1'b1;
          end
        end

        PRESSED: begin
          if (!btn_deb) begin
            state_reg <= IDLE;
            count_reg <= '0;
            held      <= 1'b0;
`ifdef BTN_RELEASE_PULSE_EN
            release_pulse <= 1'b1;
`endif
          end else if (tick_fast) begin
            if (count_reg == LONG_LAST) begin
              state_reg  <= REPEAT;
              count_reg  <= '0;
              long_press <= 1'b1;
            end else begin
              count_reg <= count_reg + CW'(1);
            end
          end
        end

        REPEAT: begin
          if (!btn_deb) begin
            state_reg <= IDLE;
            count_reg <= '0;
            held      <= 1'b0;
`ifdef BTN_RELEASE_PULSE_EN
            release_pulse <= 1'b1;
`endif
          end else if (tick_fast) begin
            if (count_reg == REPEAT_LAST) begin
              count_reg    <= '0;
              repeat_pulse <= 1'b1;
            end else begin
              count_reg <= count_reg + CW'(1);
            end
          end
        end

        default: begin
          state_reg <= IDLE;
          count_reg <= '0;
          held      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event with LONG_TICKS=4, REPEAT_TICKS=2 and a
// tick_fast strobe every 10 clk. Each step drives inputs 1 time unit after a
// rising edge and samples outputs 1 time unit after the next rising edge.
module tb_button_event;

  logic clk = 1'b0;
  logic rst;
  logic tick_fast;
  logic btn_deb;
  logic press, long_press, repeat_pulse, held;
`ifdef BTN_RELEASE_PULSE_EN
  logic release_pulse;
`endif

  always #5 clk = ~clk;

  button_event #(
    .LONG_TICKS  (4),
    .REPEAT_TICKS(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_fast   (tick_fast),
    .btn_deb     (btn_deb),
    .press       (press),
    .long_press  (long_press),
    .repeat_pulse(repeat_pulse),
    .held        (held)
`ifdef BTN_RELEASE_PULSE_EN
    , .release_pulse(release_pulse)
`endif
  );

  int checks = 0;
  int errors = 0;

  int phase;
  int n_press, n_long, n_rep, n_held, n_overlap, n_rel;
  int press_at, long_at, rep_at, rel_at;
  int held_now;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic clr();
    phase = 0;
    n_press = 0; n_long = 0; n_rep = 0; n_held = 0; n_overlap = 0; n_rel = 0;
    press_at = -1; long_at = -1; rep_at = -1; rel_at = -1;
  endtask

  // One clk: tick_fast strobes on every 10th step of the current test.
  task automatic step(input logic b);
    int idx;
    idx       = phase;
    btn_deb   = b;
    tick_fast = ((phase % 10) == 9);
    phase++;
    @(posedge clk);
    #1;
    if (press)        begin n_press++; press_at = idx; end
    if (long_press)   begin n_long++;  long_at  = idx; end
    if (repeat_pulse) begin n_rep++;   rep_at   = idx; end
    if (held)         n_held++;
    held_now = int'(held);
    if (int'(press) + int'(long_press) + int'(repeat_pulse) > 1) n_overlap++;
`ifdef BTN_RELEASE_PULSE_EN
    if (release_pulse) begin n_rel++; rel_at = idx; end
`endif
  endtask

  task automatic steps(input logic b, input int n);
    for (int i = 0; i < n; i++) step(b);
  endtask

  initial begin
    rst = 1'b1; btn_deb = 1'b0; tick_fast = 1'b0;
    clr();
    steps(1'b0, 2);
    chk("reset_outputs", int'(press) + int'(long_press) + int'(repeat_pulse) + int'(held), 0);
    rst = 1'b0;

    // Short press: no long_press, held drops one clk after release.
    clr();
    steps(1'b0, 5);
    steps(1'b1, 25);
    chk("t1_held_before_fall", held_now, 1);
    step(1'b0);
    chk("t1_held_after_fall", held_now, 0);
    steps(1'b0, 15);
    chk("t1_press_count", n_press, 1);
    chk("t1_press_step", press_at, 5);
    chk("t1_long_count", n_long, 0);
`ifdef BTN_RELEASE_PULSE_EN
    chk("t1_release_count", n_rel, 1);
    chk("t1_release_step", rel_at, 30);
`endif

    // Long hold: press at 0, long after 4th tick (step 39), repeats at 59/79/99.
    clr();
    steps(1'b1, 100);
    chk("t2_press_step", press_at, 0);
    chk("t2_long_count", n_long, 1);
    chk("t2_long_step", long_at, 39);
    chk("t2_repeat_count", n_rep, 3);
    chk("t2_last_repeat_step", rep_at, 99);
    chk("t2_overlap", n_overlap, 0);
    steps(1'b0, 3);

    // Held through reset: nothing until a 0 sample re-arms.
    rst = 1'b1;
    clr();
    steps(1'b1, 3);
    rst = 1'b0;
    steps(1'b1, 50);
    chk("t3_no_press", n_press, 0);
    chk("t3_no_long", n_long, 0);
    chk("t3_no_held", n_held, 0);
    step(1'b0);
    step(1'b1);
    chk("t3_rearm_press", n_press, 1);
    steps(1'b0, 3);

    // Release on the same clk as the 4th tick: release wins.
    clr();
    steps(1'b1, 39);
    chk("t4_held_pre", held_now, 1);
    step(1'b0);
    chk("t4_held_after", held_now, 0);
    steps(1'b0, 30);
    chk("t4_no_long", n_long, 0);
`ifdef BTN_RELEASE_PULSE_EN
    chk("t4_release_step", rel_at, 39);
`endif

    // Reset mid-REPEAT: outputs clear at once, no events until re-arm.
    clr();
    steps(1'b1, 65);
    chk("t5_repeat_before_rst", n_rep, 1);
    chk("t5_held_before_rst", held_now, 1);
    clr();
    rst = 1'b1;
    #2;
    chk("t5_async_clear", int'(press) + int'(long_press) + int'(repeat_pulse) + int'(held), 0);
    steps(1'b1, 2);
    rst = 1'b0;
    steps(1'b1, 40);
    chk("t5_no_press", n_press, 0);
    chk("t5_no_repeat", n_rep, 0);
    chk("t5_no_held", n_held, 0);
`ifdef BTN_RELEASE_PULSE_EN
    chk("t5_no_release_on_rst", n_rel, 0);
`endif
    step(1'b0);
    clr();
    steps(1'b1, 40);
    chk("t5_new_press", n_press, 1);
    chk("t5_new_long_step", long_at, 39);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
